// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch front end. Issues sequential fetch requests to an
// in-order instruction memory, buffers returned words in a 2-entry FIFO of
// {pc, inst}, and hands them to decode with a valid/ready handshake.
// Supports redirect (flush and restart) and halt (stop fetching, let
// in-flight words drain to decode).
//
// Optional feature: define IFU_PERF_CNT_EN to add the two performance
// counter outputs (perf_fetch_cnt, perf_stall_cnt).
//
// Ports:
//   clk              clock
//   reset            synchronous, active-low reset
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch address (low two bits ignored)
//   halt             stop issuing fetches
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts request
//   imem_req_addr    fetch address
//   imem_resp_valid  instruction word returned, in request order
//   imem_resp_data   instruction word
//   inst_valid       instruction available to decode
//   inst_ready       decode consumes instruction
//   inst_data        instruction word (FIFO head)
//   inst_pc          address of inst_data
//   perf_fetch_cnt   (IFU_PERF_CNT_EN) decode handshakes
//   perf_stall_cnt   (IFU_PERF_CNT_EN) cycles decode starved in FETCH/DRAIN
// -----------------------------------------------------------------------------
module inst_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [1:0]  out_cnt_reg, out_cnt_next;
  logic [1:0]  occ_reg, occ_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        drop_reg, drop_next;

  logic [31:0] pc_mem   [0:1];
  logic [31:0] data_mem [0:1];

  logic        req_fire;
  logic        pop_fire;
  logic        flush;
  logic        discard;
  logic        push_en;
  logic        pop_en;
  logic [2:0]  inflight;
  logic [31:0] resp_pc;

  // Slots are reserved from request issue until the word leaves the FIFO,
  // so a word popped this cycle only frees its slot next cycle.
  assign inflight       = {1'b0, out_cnt_reg} + {1'b0, occ_reg};
  assign imem_req_valid = reset & (state_reg == ST_FETCH) & (inflight < 3'd2);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = (occ_reg != 2'd0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr_reg] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 32'd0;
  assign pop_fire   = inst_valid & inst_ready;

  // Whenever a response is kept, the outstanding requests are the most recent
  // sequential fetches, so the oldest one sits out_cnt words behind fetch_pc.
  assign resp_pc = fetch_pc_reg - {28'd0, out_cnt_reg, 2'b00};

  // In DRAIN every outstanding response belongs to the abandoned stream;
  // drop_reg keeps that true after a halt taken from DRAIN.
  assign discard = (state_reg == ST_DRAIN) | drop_reg;
  assign push_en = imem_resp_valid & ~discard & ~flush;
  assign pop_en  = pop_fire & ~flush;

  always_comb begin
    out_cnt_next = out_cnt_reg;
    case ({req_fire, imem_resp_valid})
      2'b10:   out_cnt_next = out_cnt_reg + 2'd1;
      2'b01:   out_cnt_next = out_cnt_reg - 2'd1;
      default: out_cnt_next = out_cnt_reg;
    endcase
  end

  // FSM next-state; halt takes priority over redirect in FETCH and DRAIN.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    drop_next     = drop_reg;
    flush         = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (halt) begin
          state_next = ST_STOP;
          if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
        end else if (redirect_valid) begin
          flush         = 1'b1;
          fetch_pc_next = {redirect_pc[31:2], 2'b00};
          state_next    = (out_cnt_next == 2'd0) ? ST_FETCH : ST_DRAIN;
        end else if (req_fire) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      ST_DRAIN: begin
        if (halt) begin
          state_next = ST_STOP;
          drop_next  = 1'b1;
        end else begin
          if (redirect_valid) fetch_pc_next = {redirect_pc[31:2], 2'b00};
          if (out_cnt_next == 2'd0) state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    occ_next    = occ_reg;
    if (flush) begin
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      occ_next    = 2'd0;
    end else begin
      if (push_en) wr_ptr_next = ~wr_ptr_reg;
      if (pop_en)  rd_ptr_next = ~rd_ptr_reg;
      case ({push_en, pop_en})
        2'b10:   occ_next = occ_reg + 2'd1;
        2'b01:   occ_next = occ_reg - 2'd1;
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_FETCH;
      fetch_pc_reg <= 32'd0;
      out_cnt_reg  <= 2'd0;
      occ_reg      <= 2'd0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      out_cnt_reg  <= out_cnt_next;
      occ_reg      <= occ_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      drop_reg     <= drop_next;
    end
  end

  // FIFO storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_ptr_reg]   <= resp_pc;
      data_mem[wr_ptr_reg] <= imem_resp_data;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [31:0] perf_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt_reg <= 32'd0;
      perf_stall_cnt_reg <= 32'd0;
    end else begin
      if (pop_fire)
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      if (inst_ready & ~inst_valid & (state_reg != ST_STOP))
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule
